// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: FSM states,
// RISC-V load/store funct3 encodings and the access legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unsigned sizes exist only for loads; halfwords need even, words need
    // 4-byte aligned addresses; a simultaneous load and store is never legal.
    function automatic logic access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] addr_lo
    );
        logic ok;
        ok = 1'b0;
        if (!(rd && wr)) begin
            case (f3)
                LB:      ok = 1'b1;
                LH:      ok = !addr_lo[0];
                LW:      ok = (addr_lo == 2'b00);
                LBU:     ok = !wr;
                LHU:     ok = !wr && !addr_lo[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// plus load byte/halfword extraction with sign or zero extension.
module load_store_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] rd_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign rd_shifted = rd_word_i >> {addr_lo_i, 3'b000};
    assign ld_byte    = rd_shifted[7:0];
    assign ld_half    = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_data_i;
        case (funct3_i)
            SB: begin
                st_be_o    = 4'b0001 << addr_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SH: begin
                st_be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data_o = rd_word_i;
        case (funct3_i)
            LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
            LBU:     ld_data_o = {24'd0, ld_byte};
            LHU:     ld_data_o = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage bridge: turns core loads/stores into word-aligned valid/ready
// bus transactions, stalls the pipeline meanwhile and flags bad or timed-out accesses.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ram_address,
    input  logic [31:0] ram_w_data,
    input  logic        read_write_ram_en,
    input  logic        mem_read,
    input  logic [2:0]  funct3_m,
    output logic [31:0] ram_r_data,
    output logic        mem_stall,
    output logic        access_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;
    logic [31:0] ram_r_data_q, ram_r_data_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic        access_err_q, access_err_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        core_req;
    logic        core_legal;
    logic [2:0]  align_f3;
    logic [1:0]  align_addr;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign core_req   = mem_read || read_write_ram_en;
    assign core_legal = access_legal(mem_read, read_write_ram_en, funct3_m, ram_address[1:0]);
    assign cnt_inc    = {1'b0, cnt_q} + 17'd1;

    // Live core inputs feed store steering in IDLE; captured values feed load extraction later.
    assign align_f3   = (state_q == ST_IDLE) ? funct3_m          : funct3_q;
    assign align_addr = (state_q == ST_IDLE) ? ram_address[1:0] : addr_lo_q;

    load_store_align u_align (
        .funct3_i   (align_f3),
        .addr_lo_i  (align_addr),
        .st_data_i  (ram_w_data),
        .rd_word_i  (bus_rdata),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ram_r_data_d    = ram_r_data_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        bus_be_d        = bus_be_q;
        bus_we_d        = bus_we_q;
        bus_req_valid_d = bus_req_valid_q;
        access_err_d    = 1'b0;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;
        mem_stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core_req && core_legal) begin
                    mem_stall       = 1'b1;
                    bus_addr_d      = {ram_address[31:2], 2'b00};
                    bus_we_d        = read_write_ram_en;
                    bus_be_d        = read_write_ram_en ? st_be : BE_WORD;
                    bus_wdata_d     = read_write_ram_en ? st_wdata : bus_wdata_q;
                    bus_req_valid_d = 1'b1;
                    funct3_d        = funct3_m;
                    addr_lo_d       = ram_address[1:0];
                    state_d         = ST_REQ;
                end else if (core_req) begin
                    access_err_d = 1'b1;
                    ram_r_data_d = 32'd0;
                end
            end

            ST_REQ: begin
                mem_stall = 1'b1;
                if (bus_req_ready) begin
                    bus_req_valid_d = 1'b0;
                    cnt_d           = 16'd0;
                    state_d         = bus_we_q ? ST_DONE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                mem_stall = 1'b1;
                if (bus_rsp_valid) begin
                    ram_r_data_d = ld_data;
                    cnt_d        = 16'd0;
                    state_d      = ST_DONE;
                end else if (cnt_inc >= TIMEOUT_W) begin
                    access_err_d = 1'b1;
                    ram_r_data_d = 32'd0;
                    cnt_d        = 16'd0;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 16'd0;
            ram_r_data_q    <= 32'd0;
            bus_addr_q      <= 32'd0;
            bus_wdata_q     <= 32'd0;
            bus_be_q        <= 4'd0;
            bus_we_q        <= 1'b0;
            bus_req_valid_q <= 1'b0;
            access_err_q    <= 1'b0;
            funct3_q        <= 3'd0;
            addr_lo_q       <= 2'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ram_r_data_q    <= ram_r_data_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_be_q        <= bus_be_d;
            bus_we_q        <= bus_we_d;
            bus_req_valid_q <= bus_req_valid_d;
            access_err_q    <= access_err_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
        end
    end

    assign ram_r_data    = ram_r_data_q;
    assign access_err    = access_err_q;
    assign bus_req_valid = bus_req_valid_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Memory-stage bridge between the pipelined core's EX/MEM outputs and an external single-port data memory bus with valid/ready handshakes. It converts core loads and stores into word-aligned bus transactions with byte enables, and sign- or zero-extends load data back to the MEM/WB register. It stalls the pipeline for the duration of each access and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a read is aborted; range 1–65535.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- ram_address  in  32  byte address from EX/MEM ALU result.
- ram_w_data  in  32  store data, with the value in bits [7:0] / [15:0] / [31:0].
- read_write_ram_en  in  1  store request (EX/MEM mem_write).
- mem_read  in  1  load request (EX/MEM result_src == 01).
- funct3_m  in  3  access size and signedness.
- ram_r_data  out  32  extended load data, valid in the DONE cycle and held until the next load completes.
- mem_stall  out  1  holds stages F through M while high.
- access_err  out  1  one-cycle pulse on an aborted access.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, ram_address[31:2] followed by 2'b00.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables; 4'b1111 for reads.
- bus_rsp_valid  in  1  read data valid.
- bus_rdata  in  32  read data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE, access requested** (mem_read or read_write_ram_en high):
  - If valid, capture address, data, funct3 and type into registers, drive mem_stall = 1 combinationally, go to REQ.
  - If invalid, pulse access_err, hold mem_stall = 0, do not go to the bus, set ram_r_data = 0, stay in IDLE.
- **Invalid access** is any of:
  - mem_read and read_write_ram_en both high.
  - funct3 is 011, 110 or 111, or funct3 is 100 or 101 on a store.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
- **REQ:**
  - Hold bus_req_valid = 1 with stable address, data, be and we until bus_req_ready is high.
  - On handshake, a write goes to DONE (posted write) and a read goes to WAIT.
- **WAIT:**
  - On bus_rsp_valid, capture the extended bus_rdata and go to DONE.
  - A counter that increments each WAIT cycle reaching TIMEOUT_CYCLES aborts the read: pulse access_err, set ram_r_data = 0, go to DONE.
- **DONE:** mem_stall = 0 for exactly one cycle so the pipeline advances, then return to IDLE.
  - IDLE then evaluates the next instruction's request; back-to-back accesses are legal.
- **Store lanes:**
  - sb: be = 0001 << addr[1:0], wdata = {4{w[7:0]}}.
  - sh: be = 0011 << {addr[1], 1'b0}, wdata = {2{w[15:0]}}.
  - sw: be = 1111.
- **Load extract:** select the byte or halfword by addr[1:0] / addr[1].
  - lb and lh sign-extend from bit 7 / bit 15.
  - lbu and lhu zero-extend.
  - lw passes bus_rdata through unchanged.
- bus_rsp_valid outside WAIT is ignored.
- bus_req_ready outside REQ is ignored.

## Timing
- **Reset values:**
  - state = IDLE; counter = 0.
  - ram_r_data, bus_addr, bus_wdata = 0.
  - bus_be = 0; bus_we, bus_req_valid, access_err = 0.
  - mem_stall = 0.
- **Reset mid-operation:** the FSM returns to IDLE and bus_req_valid drops the next edge even mid-handshake. The bus slave must tolerate the abandoned request.
- **Minimum latency with ready and response immediate:**
  - Store: 2 stall cycles (IDLE, REQ), then DONE.
  - Load: 3 stall cycles (IDLE, REQ, WAIT), then DONE.
- Each extra cycle of ready or response delay adds one stall cycle.
- Registered outputs: bus_*, ram_r_data, access_err.
- Combinational outputs: mem_stall, decoded from state plus the IDLE request.
- Core inputs are sampled only in IDLE and are not required to be stable afterwards.

## Structure
- Package dmem_pkg holds:
  - The state enum.
  - The funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - A BE_WORD constant.
- Sub-module load_store_align (combinational) performs lane and byte-enable generation and load extraction/extension, taking funct3, addr[1:0], store data and bus_rdata.
- data_mem_ctrl owns the FSM, timeout counter and capture registers.

## Test plan
- sb at 0x103 with w = 0x000000A5, ready immediate → bus_addr = 0x100, be = 1000, wdata = 0xA5A5A5A5; mem_stall high for 2 cycles.
- lh at 0x202, rdata = 0x8001_1234 after 2 WAIT cycles → ram_r_data = 0xFFFF8001; stall for 4 cycles.
- lbu at 0x201, rdata = 0x0000_F000 → ram_r_data = 0x000000F0; lw at 0x200 → 0x0000F000.
- lw at 0x202 → access_err pulses 1 cycle, no bus_req_valid, stall = 0; funct3 = 011 gives the same result.
- Read with response never returned, TIMEOUT_CYCLES = 4 → access_err after 4 WAIT cycles, ram_r_data = 0, FSM back in IDLE 2 cycles later.
- Reset low during REQ with ready held low → next cycle bus_req_valid = 0, stall = 0, state IDLE; a following sw completes normally.
